// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register write port.
//   resp_t          : AXI B-channel response codes
//   wr_port_state_t : write-port FSM states
`timescale 1ns/1ps
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    RESP  = 2'b10
  } wr_port_state_t;

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// One-entry holding register with a valid flag.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset (clears valid only)
//   load          : capture d and set valid
//   clear         : drop valid; wins over load
//   d / q         : W-bit payload in / held payload out
//   valid         : entry occupied
`timescale 1ns/1ps
module axi4_lite_hold_reg #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Clear wins: a load and clear in the same cycle belong to one transaction
  // that is being retired immediately (decode error path).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/axi4_lite_wr_reg_port.sv
// AXI4-Lite write slave that turns each AW+W pair into one register write on
// a simple request/ready port and returns a B response. One transaction at a
// time; AW and W are captured independently in their own hold registers.
// Ports:
//   aclk, aresetn              : clock, synchronous active-low reset
//   awvalid/awready/awaddr     : AXI write address channel
//   wvalid/wready/wdata/wstrb  : AXI write data channel
//   bvalid/bready/bresp/bid    : AXI write response channel (bid tied to 0)
//   reg_wr_en/reg_wr_ready     : register write request / sink accept
//   reg_wr_idx/data/be         : register word index, data, byte enables
// Build option: AXI4_LITE_WR_REG_PORT_WSTRB_EN forwards the captured wstrb as
// reg_wr_be; otherwise every byte is enabled.
`timescale 1ns/1ps
module axi4_lite_wr_reg_port
  import axi4_lite_pkg::*;
#(
  parameter int A = 32,
  parameter int N = 4,
  parameter int R = 16,
  parameter int I = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [A-1:0]          awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [8*N-1:0]        wdata,
  input  logic [N-1:0]          wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic [I-1:0]          bid,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ready,
  output logic [$clog2(R)-1:0]  reg_wr_idx,
  output logic [8*N-1:0]        reg_wr_data,
  output logic [N-1:0]          reg_wr_be
);

  localparam int LOG2N = $clog2(N);
  localparam int WA_W  = A - LOG2N;
  localparam int IDX_W = $clog2(R);
  localparam int WD_W  = 8*N + N;

  wr_port_state_t state_q, state_d;
  resp_t          bresp_q, bresp_d;

  logic            aw_held, w_held;
  logic            aw_load, w_load;
  logic            aw_have, w_have;
  logic            hold_clr;
  logic            addr_ok;
  logic [WA_W-1:0] aw_q;
  logic [WA_W-1:0] word_sel;
  logic [WD_W-1:0] w_q;

  // Byte-offset address bits carry no meaning for word registers.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^awaddr[LOG2N-1:0];

  assign awready = aresetn & ~aw_held & (state_q == IDLE);
  assign wready  = aresetn & ~w_held  & (state_q == IDLE);
  assign aw_load = awvalid & awready;
  assign w_load  = wvalid & wready;

  // "Have" includes a capture happening this cycle, so AW+W arriving together
  // leave IDLE on the same edge that captures them.
  assign aw_have = aw_held | aw_load;
  assign w_have  = w_held  | w_load;

  assign word_sel = aw_held ? aw_q : awaddr[A-1:LOG2N];
  assign addr_ok  = (word_sel < WA_W'(R));

  axi4_lite_hold_reg #(.W(WA_W)) u_aw_hold (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (aw_load),
    .clear   (hold_clr),
    .d       (awaddr[A-1:LOG2N]),
    .valid   (aw_held),
    .q       (aw_q)
  );

  axi4_lite_hold_reg #(.W(WD_W)) u_w_hold (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (w_load),
    .clear   (hold_clr),
    .d       ({wdata, wstrb}),
    .valid   (w_held),
    .q       (w_q)
  );

  always_comb begin
    state_d  = state_q;
    bresp_d  = bresp_q;
    hold_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_have && w_have) begin
          if (addr_ok) begin
            state_d = WRITE;
          end else begin
            // Out-of-range index: no register write, answer straight away.
            state_d  = RESP;
            bresp_d  = SLVERR;
            hold_clr = 1'b1;
          end
        end
      end
      WRITE: begin
        if (reg_wr_ready) begin
          state_d  = RESP;
          bresp_d  = OKAY;
          hold_clr = 1'b1;
        end
      end
      RESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      bresp_q <= OKAY;
    end else begin
      state_q <= state_d;
      bresp_q <= bresp_d;
    end
  end

  // Outputs are forced to zero whenever no request/response is presented,
  // which also covers the reset cycles.
  assign reg_wr_en   = aresetn & (state_q == WRITE);
  assign reg_wr_idx  = reg_wr_en ? aw_q[IDX_W-1:0] : '0;
  assign reg_wr_data = reg_wr_en ? w_q[WD_W-1:N] : '0;

`ifdef AXI4_LITE_WR_REG_PORT_WSTRB_EN
  assign reg_wr_be = reg_wr_en ? w_q[N-1:0] : '0;
`else
  logic unused_strb;
  assign unused_strb = ^w_q[N-1:0];
  assign reg_wr_be   = reg_wr_en ? {N{1'b1}} : '0;
`endif

  assign bvalid = aresetn & (state_q == RESP);
  assign bresp  = bvalid ? bresp_q : OKAY;
  assign bid    = '0;

endmodule

// File: tb/tb_axi4_lite_wr_reg_port.sv
`timescale 1ns/1ps
module tb_axi4_lite_wr_reg_port;

  localparam int R = 16;
  localparam int N = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [0:0]  bid;
  logic        reg_wr_en;
  logic        reg_wr_ready;
  logic [3:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_be;

  bit   rand_mode = 1'b0;
  logic dir_rdy = 1'b0, dir_bready = 1'b0;
  logic rnd_rdy = 1'b0, rnd_bready = 1'b0;
  assign reg_wr_ready = rand_mode ? rnd_rdy : dir_rdy;
  assign bready       = rand_mode ? rnd_bready : dir_bready;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] bq[$];
  wr_t        exp_wr;
  logic [1:0] exp_resp = 2'b00;
  bit         exp_ok = 1'b1;
  bit         aw_pend = 0, w_pend = 0, en_stall = 0, b_stall = 0;

  axi4_lite_wr_reg_port dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .reg_wr_en(reg_wr_en), .reg_wr_ready(reg_wr_ready),
    .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data), .reg_wr_be(reg_wr_be)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: word index = byte address / N, valid below R.
  task automatic set_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned widx;
    widx        = a / N;
    exp_ok      = (widx < R);
    exp_resp    = exp_ok ? 2'b00 : 2'b10;
    exp_wr.idx  = 4'(widx);
    exp_wr.data = d;
`ifdef AXI4_LITE_WR_REG_PORT_WSTRB_EN
    exp_wr.be   = s;
`else
    exp_wr.be   = 4'hF;
`endif
  endtask

  always @(posedge aclk) begin
    #1;
    rnd_rdy    = ($urandom_range(0, 2) != 0);
    rnd_bready = ($urandom_range(0, 2) != 0);
  end

  // Protocol monitor: ready flags follow what the bench knows is in flight,
  // and every presented request/response matches the model.
  always @(negedge aclk) begin
    if (!aresetn) begin
      check_val("rst_awready", awready, 1'b0);
      check_val("rst_bvalid", bvalid, 1'b0);
      check_val("rst_reg_wr_en", reg_wr_en, 1'b0);
      aw_pend = 0; w_pend = 0; en_stall = 0; b_stall = 0;
    end else begin
      check_val("awready", awready, !aw_pend);
      check_val("wready", wready, !w_pend);
      if (en_stall) check_val("en_held", reg_wr_en, 1'b1);
      if (b_stall)  check_val("bvalid_held", bvalid, 1'b1);
      if (reg_wr_en) begin
        check_val("en_needs_aw_w", aw_pend && w_pend, 1'b1);
        check_val("wr_content", {reg_wr_idx, reg_wr_data, reg_wr_be}, exp_wr);
      end
      if (bvalid) check_val("bresp", bresp, exp_resp);
      en_stall = reg_wr_en && !reg_wr_ready;
      b_stall  = bvalid && !bready;
      if (reg_wr_en && reg_wr_ready) wq.push_back({reg_wr_idx, reg_wr_data, reg_wr_be});
      if (bvalid && bready) begin
        bq.push_back(bresp);
        aw_pend = 0;
        w_pend  = 0;
      end
      if (awvalid && awready) aw_pend = 1;
      if (wvalid && wready)   w_pend = 1;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_aw(input logic [31:0] a, input int d);
    bit done = 0;
    repeat (d) tick();
    awaddr = a; awvalid = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      done = awready;
      tick();
    end
    awvalid = 1'b0; awaddr = $urandom;
    check_val("aw_accepted", done, 1'b1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dl);
    bit done = 0;
    repeat (dl) tick();
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      done = wready;
      tick();
    end
    wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom);
    check_val("w_accepted", done, 1'b1);
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int daw, input int dw);
    int nw, nb;
    set_exp(a, d, s);
    nw = wq.size();
    nb = bq.size();
    fork
      drive_aw(a, daw);
      drive_w(d, s, dw);
    join
    for (int k = 0; k < 400 && bq.size() == nb; k++) tick();
    check_val("b_done", bq.size(), nb + 1);
    if (bq.size() == nb + 1) check_val("b_resp_q", bq[nb], exp_resp);
    check_val("n_writes", wq.size() - nw, exp_ok ? 1 : 0);
    if (exp_ok && wq.size() == nw + 1) check_val("wr_q", wq[nw], exp_wr);
  endtask

  task automatic chk_all_zero(input string tag);
    check_val({tag, "_outs"}, {awready, wready, bvalid, bresp, reg_wr_en, reg_wr_idx,
                               reg_wr_data, reg_wr_be}, '0);
  endtask

  initial begin
    logic [31:0] d;
    int nw, nb;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    aresetn = 1'b1;
    #1;
    check_val("post_rst_awready", awready, 1'b1);
    check_val("post_rst_wready", wready, 1'b1);
    check_val("bid", bid, 1'b0);
    tick();

    // Same-cycle AW+W, ready sink
    dir_rdy = 1'b1; dir_bready = 1'b1;
    set_exp(32'h8, 32'hDEADBEEF, 4'hF);
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    check_val("t1_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("t1_en", reg_wr_en, 1'b1);
    check_val("t1_idx", reg_wr_idx, 4'd2);
    check_val("t1_data", reg_wr_data, 32'hDEADBEEF);
    check_val("t1_be", reg_wr_be, 4'hF);
    check_val("t1_bvalid_c1", bvalid, 1'b0);
    tick();
    check_val("t1_bvalid_c2", bvalid, 1'b1);
    check_val("t1_bresp", bresp, 2'b00);
    check_val("t1_en_c2", reg_wr_en, 1'b0);
    tick();
    check_val("t1_idle_c3", {awready, wready, bvalid}, 3'b110);

    // W three cycles ahead of AW
    d = $urandom;
    set_exp(32'h4, d, 4'hF);
    nw = wq.size();
    wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("t2_wready_low", wready, 1'b0);
      check_val("t2_no_en", reg_wr_en, 1'b0);
      tick();
    end
    awaddr = 32'h4; awvalid = 1'b1;
    check_val("t2_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    check_val("t2_en", reg_wr_en, 1'b1);
    check_val("t2_idx", reg_wr_idx, 4'd1);
    repeat (3) tick();
    check_val("t2_one_write", wq.size() - nw, 1);

    // Decode error
    nw = wq.size(); nb = bq.size();
    set_exp(32'h40, 32'h1234, 4'hF);
    awaddr = 32'h40; wdata = 32'h1234; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("t3_no_en", reg_wr_en, 1'b0);
    check_val("t3_bvalid", bvalid, 1'b1);
    check_val("t3_bresp", bresp, 2'b10);
    tick();
    check_val("t3_bvalid_gone", bvalid, 1'b0);
    check_val("t3_no_write", wq.size() - nw, 0);
    check_val("t3_one_b", bq.size() - nb, 1);

    // Backpressure on both sides
    dir_rdy = 1'b0; dir_bready = 1'b0;
    d = $urandom;
    set_exp(32'h3C, d, 4'hF);
    awaddr = 32'h3C; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      check_val("t4_en", reg_wr_en, 1'b1);
      check_val("t4_idx_data", {reg_wr_idx, reg_wr_data}, {4'd15, d});
      check_val("t4_ready_low", {awready, wready}, 2'b00);
      if (i == 6) dir_rdy = 1'b1;
      tick();
    end
    dir_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check_val("t4_b", {bvalid, bresp, reg_wr_en}, 4'b1000);
      check_val("t4_b_ready_low", {awready, wready}, 2'b00);
      if (i == 5) dir_bready = 1'b1;
      tick();
    end
    check_val("t4_idle", {awready, wready, bvalid}, 3'b110);

    // Byte strobes
    dir_rdy = 1'b1;
    run_txn(32'hC, $urandom, 4'h5, 0, 0);
`ifdef AXI4_LITE_WR_REG_PORT_WSTRB_EN
    check_val("t5_be", wq[wq.size()-1].be, 4'h5);
`else
    check_val("t5_be", wq[wq.size()-1].be, 4'hF);
`endif

    // Reset in the middle of WRITE
    dir_rdy = 1'b0;
    nb = bq.size();
    set_exp(32'h10, 32'hA5A5_0F0F, 4'hF);
    awaddr = 32'h10; wdata = 32'hA5A5_0F0F; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("t6_in_write", reg_wr_en, 1'b1);
    aresetn = 1'b0;
    #1;
    chk_all_zero("t6_during_rst");
    tick();
    chk_all_zero("t6_after_edge");
    aresetn = 1'b1;
    #1;
    check_val("t6_ready_back", {awready, wready, bvalid, reg_wr_en}, 4'b1100);
    repeat (4) tick();
    check_val("t6_no_b", bq.size() - nb, 0);
    dir_rdy = 1'b1;
    run_txn(32'h0, $urandom, 4'hF, 0, 0);

    // Randomized traffic with random sink and B backpressure
    rand_mode = 1'b1;
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      run_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    rand_mode = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
